// File: rtl/muldiv_unit.sv
// Iterative RISC-V M-extension multiply/divide unit: radix-2 shift-add multiply and
// restoring divide on operand magnitudes, with sign fix-up and fast paths for divide special cases.
module muldiv_unit #(
   parameter int XLEN = 32
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            start_i,
   input  logic [2:0]      funct3_i,
   input  logic [XLEN-1:0] operand_a_i,
   input  logic [XLEN-1:0] operand_b_i,
   input  logic            flush_i,
   output logic            busy_o,
   output logic            done_o,
   output logic [XLEN-1:0] result_o,
   output logic [1:0]      state_o
);

   localparam int CW = $clog2(XLEN);
   localparam int PW = 2 * XLEN;

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t state, state_next;

   logic [CW-1:0]   count;
   logic [2:0]      op;
   logic            neg_q, neg_r;
   logic [XLEN-1:0] hi, lo, b_mag;

   logic            accept, is_div_in, a_signed_in, b_signed_in, a_neg_in, b_neg_in;
   logic            div_zero, div_ovf, fast;
   logic [XLEN-1:0] a_mag_in, b_mag_in;
   logic [XLEN:0]   mul_sum, div_trial, div_diff;
   logic [PW-1:0]   product;
   logic [XLEN-1:0] quot, rem, fixed_result;

   // Requests are only taken between operations; flush always wins over start.
   assign accept      = start_i && !flush_i && (state == IDLE || state == DONE);
   assign is_div_in   = funct3_i[2];
   assign a_signed_in = is_div_in ? !funct3_i[0] : (funct3_i != 3'b011);
   assign b_signed_in = is_div_in ? !funct3_i[0] : !funct3_i[1];
   assign a_neg_in    = a_signed_in && operand_a_i[XLEN-1];
   assign b_neg_in    = b_signed_in && operand_b_i[XLEN-1];
   assign a_mag_in    = a_neg_in ? ~operand_a_i + XLEN'(1) : operand_a_i;
   assign b_mag_in    = b_neg_in ? ~operand_b_i + XLEN'(1) : operand_b_i;
   assign div_zero    = is_div_in && (operand_b_i == '0);
   assign div_ovf     = is_div_in && !funct3_i[0] && (operand_b_i == '1) &&
                        (operand_a_i == {1'b1, {(XLEN-1){1'b0}}});
   assign fast        = div_zero || div_ovf;

   // hi/lo hold {product_hi, multiplier} for multiply and {remainder, dividend/quotient} for divide.
   assign mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, b_mag} : '0);
   assign div_trial = {hi, lo[XLEN-1]};
   assign div_diff  = div_trial - {1'b0, b_mag};

   always_comb begin
      product = {hi, lo};
      if (neg_q) product = ~product + PW'(1);
      quot = neg_q ? ~lo + XLEN'(1) : lo;
      rem  = neg_r ? ~hi + XLEN'(1) : hi;
      case (op)
         3'b000:                 fixed_result = product[XLEN-1:0];
         3'b001, 3'b010, 3'b011: fixed_result = product[PW-1:XLEN];
         3'b100, 3'b101:         fixed_result = quot;
         default:                fixed_result = rem;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (accept) state_next = fast ? DONE : CALC;
         CALC: if (count == CW'(XLEN - 1)) state_next = FIX;
         FIX:  state_next = DONE;
         DONE: state_next = accept ? (fast ? DONE : CALC) : IDLE;
         default: state_next = IDLE;
      endcase
      if (flush_i) state_next = IDLE;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         count    <= '0;
         op       <= '0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         hi       <= '0;
         lo       <= '0;
         b_mag    <= '0;
         result_o <= '0;
      end else if (accept) begin
         count <= '0;
         op    <= funct3_i;
         neg_q <= a_neg_in ^ b_neg_in;
         neg_r <= a_neg_in;
         hi    <= '0;
         lo    <= a_mag_in;
         b_mag <= b_mag_in;
         if (div_zero)     result_o <= funct3_i[1] ? operand_a_i : '1;
         else if (div_ovf) result_o <= funct3_i[1] ? '0 : operand_a_i;
      end else if (state == CALC && !flush_i) begin
         count <= count + CW'(1);
         if (op[2]) begin
            // No borrow out of the trial subtraction means the divisor fits.
            if (!div_diff[XLEN]) begin
               hi <= div_diff[XLEN-1:0];
               lo <= {lo[XLEN-2:0], 1'b1};
            end else begin
               hi <= div_trial[XLEN-1:0];
               lo <= {lo[XLEN-2:0], 1'b0};
            end
         end else begin
            {hi, lo} <= {mul_sum, lo[XLEN-1:1]};
         end
      end else if (state == FIX && !flush_i) begin
         result_o <= fixed_result;
      end
   end

   assign busy_o  = (state == CALC) || (state == FIX);
   assign done_o  = (state == DONE);
   assign state_o = state;

endmodule
